// File: rtl/sprite_reader.sv
// sprite_reader: reads one 8x8 pixel block from a fixed-latency framebuffer and streams it out
// through a credit-limited FIFO. Define SPRITE_READER_BOUNDS_EN to reject out-of-frame starts.
module sprite_reader #(
  parameter int PIXEL_W    = 8,
  parameter int ROW_STRIDE = 640,
  parameter int MEM_LAT    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [18:0]        coordinates,
  output logic               busy,
  output logic               done,
  output logic               mem_rd_en,
  output logic [18:0]        mem_addr,
  input  logic [PIXEL_W-1:0] mem_rdata,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [PIXEL_W-1:0] pix_data,
  output logic [5:0]         pix_index,
  output logic               err
);
  localparam int DEPTH = MEM_LAT + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [18:0] STRIDE = 19'(ROW_STRIDE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e             state_q, state_d;
  logic               busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic               rd_en_q, rd_en_d;
  logic [18:0]        addr_q, addr_d, row_base_q, row_base_d;
  logic [5:0]         rd_cnt_q, rd_cnt_d, pix_index_q;
  logic [MEM_LAT-1:0] rd_pipe_q;
  logic [CNT_W-1:0]   inflight_q, fifo_cnt_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PIXEL_W-1:0] fifo_q [DEPTH];
  logic               push_s, pop_s, can_issue_s, oob_s;
  logic [CNT_W:0]     credit_used_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

`ifdef SPRITE_READER_BOUNDS_EN
  assign oob_s = ({13'd0, coordinates} + 32'(7 * ROW_STRIDE + 7)) > 32'd307199;
`else
  assign oob_s = 1'b0;
`endif

  // The FIFO head is the output pixel; a pop frees its credit in the same cycle.
  assign push_s        = rd_pipe_q[MEM_LAT-1];
  assign pop_s         = pix_valid & pix_ready;
  assign credit_used_s = {1'b0, fifo_cnt_q} + {1'b0, inflight_q} - (CNT_W+1)'(pop_s);
  assign can_issue_s   = credit_used_s < (CNT_W+1)'(DEPTH);

  // Next-state, read issue and address generation.
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_en_d    = 1'b0;
    addr_d     = addr_q;
    row_base_d = row_base_q;
    rd_cnt_d   = rd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start && oob_s) begin
          err_d = 1'b1;
        end else if (start) begin
          state_d    = S_ISSUE;
          busy_d     = 1'b1;
          rd_en_d    = 1'b1;
          addr_d     = coordinates;
          row_base_d = coordinates;
          rd_cnt_d   = 6'd1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (can_issue_s) begin
          rd_en_d  = 1'b1;
          rd_cnt_d = rd_cnt_q + 6'd1;
          if (rd_cnt_q[2:0] == 3'd0) begin
            addr_d     = row_base_q + STRIDE;
            row_base_d = row_base_q + STRIDE;
          end else begin
            addr_d = addr_q + 19'd1;
          end
          if (rd_cnt_q == 6'd63) begin
            state_d = S_DRAIN;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_DRAIN: begin
        if (pop_s && (pix_index_q == 6'd63)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control, address and credit bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_en_q     <= 1'b0;
      addr_q      <= 19'd0;
      row_base_q  <= 19'd0;
      rd_cnt_q    <= 6'd0;
      rd_pipe_q   <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pix_index_q <= 6'd0;
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_en_q    <= rd_en_d;
      addr_q     <= addr_d;
      row_base_q <= row_base_d;
      rd_cnt_q   <= rd_cnt_d;
      rd_pipe_q  <= (rd_pipe_q << 1) | MEM_LAT'(rd_en_q);
      inflight_q <= inflight_q + CNT_W'(rd_en_d) - CNT_W'(push_s);
      fifo_cnt_q <= fifo_cnt_q + CNT_W'(push_s) - CNT_W'(pop_s);
      if (push_s) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_q <= wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
        pix_index_q <= pix_index_q + 6'd1;
      end else begin
        rd_ptr_q    <= rd_ptr_q;
        pix_index_q <= pix_index_q;
      end
    end
  end

  // Pixel storage; cleared on reset so the idle head reads as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (push_s) begin
      fifo_q[wr_ptr_q] <= mem_rdata;
    end else begin
      fifo_q[wr_ptr_q] <= fifo_q[wr_ptr_q];
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign mem_rd_en = rd_en_q;
  assign mem_addr  = addr_q;
  assign pix_valid = (fifo_cnt_q != '0);
  assign pix_data  = fifo_q[rd_ptr_q];
  assign pix_index = pix_index_q;

endmodule

// File: tb/tb_sprite_reader.sv
// Directed bench for sprite_reader (default parameters, two-cycle framebuffer model).
module tb_sprite_reader;
  localparam int STRIDE = 640;

  logic        clk = 1'b0;
  logic        rst, start, pix_ready;
  logic [18:0] coordinates;
  logic        busy, done, mem_rd_en, pix_valid, err;
  logic [18:0] mem_addr;
  logic [7:0]  mem_rdata, pix_data;
  logic [5:0]  pix_index;
  logic [19:0] mp1 = 20'd0, mp2 = 20'd0;
  int          checks = 0, failures = 0;

  sprite_reader dut (
    .clk(clk), .rst(rst), .start(start), .coordinates(coordinates),
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_data(pix_data), .pix_index(pix_index), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pix_of(input logic [18:0] a);
    return a[7:0] ^ a[15:8] ^ {5'd0, a[18:16]};
  endfunction

  // Framebuffer model: data valid two cycles after the read strobe, junk otherwise.
  always @(posedge clk) begin
    mp1 <= {mem_rd_en, mem_addr};
    mp2 <= mp1;
  end
  assign mem_rdata = mp2[19] ? pix_of(mp2[18:0]) : 8'hEE;

  function automatic logic [18:0] addr_of(input logic [18:0] base, input int n);
    return base + 19'((n >> 3) * STRIDE) + 19'(n & 7);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_rden"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_pvld"}, pix_valid, 0);
    chk({tag, "_pdata"}, pix_data, 0);
    chk({tag, "_pidx"}, pix_index, 0);
  endtask

  // mode 0: ready high; 1: ready on even cycles; 2: ready low 100 cycles;
  // 3: ready high plus a second start while busy. Returns in the done cycle.
  task automatic run_block(input logic [18:0] base, input int mode);
    int r, n, first_v, done_e;
    logic hs63, held;
    logic [7:0] hd;
    logic [5:0] hi;
    r = 0; n = 0; first_v = -1; done_e = -1; hs63 = 1'b0; held = 1'b0; hd = 8'd0; hi = 6'd0;
    start = 1'b1;
    coordinates = base;
    tick();
    for (int e = 0; e < 400; e++) begin
      if (mode == 3 && e == 10) begin
        start = 1'b1;
        coordinates = base + 19'd5000;
      end else begin
        start = 1'b0;
      end
      case (mode)
        1: pix_ready = (e % 2 == 0);
        2: pix_ready = (e >= 100);
        default: pix_ready = 1'b1;
      endcase
      chk("busy", busy, (n < 64));
      chk("done", done, hs63);
      chk("err", err, 0);
      if (hs63) begin
        done_e = e;
        break;
      end
      if (mem_rd_en) begin
        chk("addr", mem_addr, addr_of(base, r));
        r++;
      end
      chk("credit", (r - n <= 4), 1);
      if (mode == 2 && e == 100) chk("stall_reads", r, 4);
      if (held) begin
        chk("hold_valid", pix_valid, 1);
        chk("hold_data", pix_data, hd);
        chk("hold_index", pix_index, hi);
      end
      held = pix_valid && !pix_ready;
      hd = pix_data;
      hi = pix_index;
      if (pix_valid && first_v < 0) first_v = e;
      hs63 = 1'b0;
      if (pix_valid && pix_ready) begin
        chk("data", pix_data, pix_of(addr_of(base, n)));
        chk("index", pix_index, n);
        hs63 = (n == 63);
        n++;
      end
      tick();
    end
    chk("reads_total", r, 64);
    chk("pixels_total", n, 64);
    chk("done_seen", (done_e >= 0), 1);
    if (mode == 0) begin
      chk("first_valid_cycle", first_v, 3);
      chk("done_cycle", done_e, 67);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    pix_ready = 1'b0;
    coordinates = 19'd0;
    tick();
    tick();
    chk_reset_vals("init");
    rst = 1'b0;
    tick();
    chk_reset_vals("idle");

    run_block(19'd0, 0);
    run_block(19'd1000, 1);
    run_block(19'd123, 2);
    run_block(19'd7, 3);

    // Abort mid-block, release before the next edge while stale reads are still returning.
    start = 1'b1;
    coordinates = 19'd2000;
    pix_ready = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 200; k++) begin
      if (pix_valid && pix_index == 6'd30) break;
      tick();
    end
    chk("pre_rst_index", pix_index, 30);
    rst = 1'b1;
    #1;
    chk_reset_vals("midrst");
    #1;
    rst = 1'b0;
    run_block(19'd640, 0);

`ifdef SPRITE_READER_BOUNDS_EN
    start = 1'b1;
    coordinates = 19'd303000;
    tick();
    start = 1'b0;
    chk("oob_err", err, 1);
    chk("oob_busy", busy, 0);
    chk("oob_rden", mem_rd_en, 0);
    tick();
    chk("oob_err_clear", err, 0);
    for (int k = 0; k < 4; k++) begin
      chk("oob_no_read", mem_rd_en, 0);
      tick();
    end
    run_block(19'd302712, 0);
`else
    run_block(19'd524280, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
